// File: rtl/decode_stage_if.sv
// Shared widths, the ID/EX payload type, and the decode-to-execute interface.
package params_pkg;
    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned REG_AW      = 5;

    // Contents of the ID/EX pipeline register
    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] rs1_data;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic [DATA_WIDTH-1:0] imm;
        logic [REG_AW-1:0]     rd;
        logic [3:0]            alu_op;
        logic [2:0]            funct3;
        logic                  wr_en;
        logic                  is_load;
        logic                  is_store;
        logic                  is_branch;
        logic                  is_jal;
        logic                  is_jalr;
        logic                  is_lui;
        logic                  is_auipc;
        logic                  use_imm;
        logic                  illegal;
    } idex_t;
endpackage

// Registered ID/EX bus towards execute, plus execute's back-pressure
interface decode_stage_if;
    import params_pkg::*;

    logic                  ex_valid_o;
    logic [ADDR_WIDTH-1:0] ex_pc_o;
    logic [DATA_WIDTH-1:0] ex_rs1_data_o;
    logic [DATA_WIDTH-1:0] ex_rs2_data_o;
    logic [DATA_WIDTH-1:0] ex_imm_o;
    logic [REG_AW-1:0]     ex_rd_o;
    logic [3:0]            ex_alu_op_o;
    logic [2:0]            ex_funct3_o;
    logic                  ex_wr_en_o;
    logic                  ex_is_load_o;
    logic                  ex_is_store_o;
    logic                  ex_is_branch_o;
    logic                  ex_is_jal_o;
    logic                  ex_is_jalr_o;
    logic                  ex_is_lui_o;
    logic                  ex_is_auipc_o;
    logic                  ex_use_imm_o;
    logic                  ex_illegal_o;
    logic                  ex_stall_i;

    modport master (
        output ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rd_o,
               ex_alu_op_o, ex_funct3_o, ex_wr_en_o, ex_is_load_o, ex_is_store_o,
               ex_is_branch_o, ex_is_jal_o, ex_is_jalr_o, ex_is_lui_o, ex_is_auipc_o,
               ex_use_imm_o, ex_illegal_o,
        input  ex_stall_i
    );

    modport slave (
        input  ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rd_o,
               ex_alu_op_o, ex_funct3_o, ex_wr_en_o, ex_is_load_o, ex_is_store_o,
               ex_is_branch_o, ex_is_jal_o, ex_is_jalr_o, ex_is_lui_o, ex_is_auipc_o,
               ex_use_imm_o, ex_illegal_o,
        output ex_stall_i
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID capture, field/immediate decode, RAW interlock, ID/EX register.
module decode_stage
    import params_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   fetch_valid_i,
    input  logic [ADDR_WIDTH-1:0]  fetch_pc_i,
    input  logic [INSTR_WIDTH-1:0] fetch_instr_i,
    output logic                   dec_stall_o,
    input  logic                   flush_i,
    output logic [REG_AW-1:0]      rf_rs1_addr_o,
    output logic [REG_AW-1:0]      rf_rs2_addr_o,
    input  logic [DATA_WIDTH-1:0]  rf_rs1_data_i,
    input  logic [DATA_WIDTH-1:0]  rf_rs2_data_i,
    input  logic                   exm_wr_en_i,
    input  logic [REG_AW-1:0]      exm_rd_i,
    input  logic                   wb_wr_en_i,
    input  logic [REG_AW-1:0]      wb_rd_i,
    decode_stage_if.master         ex_if
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic                   ifid_valid_q, ifid_valid_d;
    logic [ADDR_WIDTH-1:0]  ifid_pc_q, ifid_pc_d;
    logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    idex_t                  idex_q, idex_d;

    idex_t                  dec_c;
    logic                   rs1_used_c, rs2_used_c, wr_c;
    logic                   rs1_haz_c, rs2_haz_c, advance_c;

    logic [6:0]             opcode;
    logic [REG_AW-1:0]      rd, rs1, rs2;
    logic [2:0]             funct3;
    logic [DATA_WIDTH-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j;

    // Instruction fields and immediate formats
    assign opcode = ifid_instr_q[6:0];
    assign rd     = ifid_instr_q[11:7];
    assign funct3 = ifid_instr_q[14:12];
    assign rs1    = ifid_instr_q[19:15];
    assign rs2    = ifid_instr_q[24:20];
    assign imm_i  = DATA_WIDTH'({{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]});
    assign imm_s  = DATA_WIDTH'({{20{ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]});
    assign imm_b  = DATA_WIDTH'({{19{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                                 ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0});
    assign imm_u  = DATA_WIDTH'({ifid_instr_q[31:12], 12'h000});
    assign imm_j  = DATA_WIDTH'({{11{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[19:12],
                                 ifid_instr_q[20], ifid_instr_q[30:21], 1'b0});

    // Decode the IF/ID instruction into an ID/EX payload
    always_comb begin
        dec_c          = '0;
        rs1_used_c     = 1'b1;
        rs2_used_c     = 1'b0;
        wr_c           = 1'b0;
        dec_c.valid    = 1'b1;
        dec_c.pc       = ifid_pc_q;
        dec_c.rs1_data = rf_rs1_data_i;
        dec_c.rs2_data = rf_rs2_data_i;
        dec_c.rd       = rd;
        dec_c.funct3   = funct3;
        dec_c.use_imm  = 1'b1;
        case (opcode)
            OPC_LUI: begin
                dec_c.is_lui = 1'b1; dec_c.imm = imm_u; wr_c = 1'b1; rs1_used_c = 1'b0;
            end
            OPC_AUIPC: begin
                dec_c.is_auipc = 1'b1; dec_c.imm = imm_u; wr_c = 1'b1; rs1_used_c = 1'b0;
            end
            OPC_JAL: begin
                dec_c.is_jal = 1'b1; dec_c.imm = imm_j; wr_c = 1'b1; rs1_used_c = 1'b0;
            end
            OPC_JALR: begin
                dec_c.is_jalr = 1'b1; dec_c.imm = imm_i; wr_c = 1'b1;
            end
            OPC_BRANCH: begin
                dec_c.is_branch = 1'b1; dec_c.imm = imm_b; dec_c.use_imm = 1'b0; rs2_used_c = 1'b1;
            end
            OPC_LOAD: begin
                dec_c.is_load = 1'b1; dec_c.imm = imm_i; wr_c = 1'b1;
            end
            OPC_STORE: begin
                dec_c.is_store = 1'b1; dec_c.imm = imm_s; rs2_used_c = 1'b1;
            end
            OPC_OPIMM: begin
                dec_c.imm    = imm_i;
                wr_c         = 1'b1;
                dec_c.alu_op = (funct3 == 3'b101) ? {ifid_instr_q[30], funct3} : {1'b0, funct3};
            end
            OPC_OP: begin
                dec_c.use_imm = 1'b0;
                wr_c          = 1'b1;
                rs2_used_c    = 1'b1;
                dec_c.alu_op  = {ifid_instr_q[30], funct3};
            end
            default: dec_c.illegal = ifid_valid_q;
        endcase
        dec_c.wr_en = wr_c & (rd != '0);
    end

    // RAW interlock against every in-flight writer (no forwarding, x0 exempt)
    always_comb begin
        rs1_haz_c = rs1_used_c && (rs1 != '0) &&
                    ((idex_q.valid && idex_q.wr_en && (idex_q.rd == rs1)) ||
                     (exm_wr_en_i && (exm_rd_i == rs1)) ||
                     (wb_wr_en_i  && (wb_rd_i  == rs1)));
        rs2_haz_c = rs2_used_c && (rs2 != '0) &&
                    ((idex_q.valid && idex_q.wr_en && (idex_q.rd == rs2)) ||
                     (exm_wr_en_i && (exm_rd_i == rs2)) ||
                     (wb_wr_en_i  && (wb_rd_i  == rs2)));
        advance_c = ifid_valid_q && !rs1_haz_c && !rs2_haz_c && !ex_if.ex_stall_i;
    end

    assign dec_stall_o   = ifid_valid_q && !advance_c;
    assign rf_rs1_addr_o = rs1;
    assign rf_rs2_addr_o = rs2;

    // Next-state for IF/ID and ID/EX
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        if (flush_i) begin
            ifid_valid_d = 1'b0;
        end else if (!ifid_valid_q || advance_c) begin
            ifid_valid_d = fetch_valid_i;
            ifid_pc_d    = fetch_pc_i;
            ifid_instr_d = fetch_instr_i;
        end

        idex_d = idex_q;
        if (flush_i) begin
            idex_d.valid = 1'b0;
        end else if (ex_if.ex_stall_i) begin
            idex_d = idex_q;
        end else if (advance_c) begin
            idex_d = dec_c;
        end else begin
            idex_d.valid = 1'b0;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            idex_q       <= '0;
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            idex_q       <= idex_d;
        end
    end

    assign ex_if.ex_valid_o     = idex_q.valid;
    assign ex_if.ex_pc_o        = idex_q.pc;
    assign ex_if.ex_rs1_data_o  = idex_q.rs1_data;
    assign ex_if.ex_rs2_data_o  = idex_q.rs2_data;
    assign ex_if.ex_imm_o       = idex_q.imm;
    assign ex_if.ex_rd_o        = idex_q.rd;
    assign ex_if.ex_alu_op_o    = idex_q.alu_op;
    assign ex_if.ex_funct3_o    = idex_q.funct3;
    assign ex_if.ex_wr_en_o     = idex_q.wr_en;
    assign ex_if.ex_is_load_o   = idex_q.is_load;
    assign ex_if.ex_is_store_o  = idex_q.is_store;
    assign ex_if.ex_is_branch_o = idex_q.is_branch;
    assign ex_if.ex_is_jal_o    = idex_q.is_jal;
    assign ex_if.ex_is_jalr_o   = idex_q.is_jalr;
    assign ex_if.ex_is_lui_o    = idex_q.is_lui;
    assign ex_if.ex_is_auipc_o  = idex_q.is_auipc;
    assign ex_if.ex_use_imm_o   = idex_q.use_imm;
    assign ex_if.ex_illegal_o   = idex_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a simple EX/MEM -> MEM/WB writer model downstream.
module tb_decode_stage;
    localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;
    localparam logic [31:0] ADDI_X2_7  = 32'h0070_0113;
    localparam logic [31:0] ADDI_X4_9  = 32'h0090_0213;
    localparam logic [31:0] ADD_X3     = 32'h0010_81B3;
    localparam logic [31:0] ADDI_X0_1  = 32'h0010_0013;
    localparam logic [31:0] SW_X5_M4   = 32'hFE51_2E23;
    localparam logic [31:0] SRAI_X6    = 32'h4030_D313;
    localparam logic [31:0] ILLEGAL    = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic [31:0] fetch_instr = '0;
    logic        dec_stall;
    logic        flush = 1'b0;
    logic        ex_stall = 1'b0;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        exm_wr_en, wb_wr_en;
    logic [4:0]  exm_rd, wb_rd;

    logic        mdl_exm_we, mdl_wb_we;
    logic [4:0]  mdl_exm_rd, mdl_wb_rd;
    logic        ovr_en = 1'b0;
    logic        ovr_exm_we = 1'b0;
    logic [4:0]  ovr_exm_rd = '0;

    int n_tests = 0;
    int n_fail  = 0;

    decode_stage_if ex_if();

    decode_stage dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .fetch_valid_i (fetch_valid),
        .fetch_pc_i    (fetch_pc),
        .fetch_instr_i (fetch_instr),
        .dec_stall_o   (dec_stall),
        .flush_i       (flush),
        .rf_rs1_addr_o (rf_rs1_addr),
        .rf_rs2_addr_o (rf_rs2_addr),
        .rf_rs1_data_i (rf_rs1_data),
        .rf_rs2_data_i (rf_rs2_data),
        .exm_wr_en_i   (exm_wr_en),
        .exm_rd_i      (exm_rd),
        .wb_wr_en_i    (wb_wr_en),
        .wb_rd_i       (wb_rd),
        .ex_if         (ex_if)
    );

    always #5 clk = ~clk;

    // Register file stand-in: data encodes the address read
    assign rf_rs1_data = 32'h1000_0000 | 32'(rf_rs1_addr);
    assign rf_rs2_data = 32'h1000_0000 | 32'(rf_rs2_addr);
    assign ex_if.ex_stall_i = ex_stall;
    assign exm_wr_en = ovr_en ? ovr_exm_we : mdl_exm_we;
    assign exm_rd    = ovr_en ? ovr_exm_rd : mdl_exm_rd;
    assign wb_wr_en  = mdl_wb_we;
    assign wb_rd     = mdl_wb_rd;

    // Downstream writers: ID/EX -> EX/MEM -> MEM/WB -> retired
    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            mdl_exm_we <= 1'b0; mdl_exm_rd <= '0;
            mdl_wb_we  <= 1'b0; mdl_wb_rd  <= '0;
        end else begin
            if (!ex_stall) begin
                mdl_exm_we <= ex_if.ex_valid_o & ex_if.ex_wr_en_o;
                mdl_exm_rd <= ex_if.ex_rd_o;
            end
            mdl_wb_we <= ex_stall ? 1'b0 : mdl_exm_we;
            mdl_wb_rd <= mdl_exm_rd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        fetch_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        fetch_instr = instr;
    endtask

    task automatic test_reset();
        #1 rst_i = 1'b0;
        #3;
        n_tests++; if (ex_if.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_ex_valid: got %0b exp 0", ex_if.ex_valid_o); end
        n_tests++; if (dec_stall !== 1'b0) begin n_fail++; $display("FAIL rst_dec_stall: got %0b exp 0", dec_stall); end
        n_tests++; if (ex_if.ex_illegal_o !== 1'b0) begin n_fail++; $display("FAIL rst_illegal: got %0b exp 0", ex_if.ex_illegal_o); end
        n_tests++; if (ex_if.ex_pc_o !== 32'h0 || ex_if.ex_imm_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc_imm: got pc %h imm %h exp 0", ex_if.ex_pc_o, ex_if.ex_imm_o); end
        n_tests++; if (rf_rs1_addr !== 5'd0 || rf_rs2_addr !== 5'd0) begin n_fail++; $display("FAIL rst_rf_addr: got %0d/%0d exp 0", rf_rs1_addr, rf_rs2_addr); end
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b1;
        idle(2);
    endtask

    task automatic test_back_to_back();
        offer(32'h0, ADDI_X1_5);
        tick();
        n_tests++; if (dec_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall0: got %0b exp 0", dec_stall); end
        offer(32'h4, ADDI_X2_7);
        tick();
        fetch_valid = 1'b0;
        #1;
        n_tests++; if (ex_if.ex_valid_o !== 1'b1 || ex_if.ex_imm_o !== 32'd5 || ex_if.ex_rd_o !== 5'd1 || ex_if.ex_pc_o !== 32'h0)
            begin n_fail++; $display("FAIL b2b_first: got v%0b imm %h rd %0d pc %h exp v1 imm 5 rd 1 pc 0", ex_if.ex_valid_o, ex_if.ex_imm_o, ex_if.ex_rd_o, ex_if.ex_pc_o); end
        n_tests++; if (dec_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall1: got %0b exp 0", dec_stall); end
        n_tests++; if (ex_if.ex_wr_en_o !== 1'b1 || ex_if.ex_use_imm_o !== 1'b1 || ex_if.ex_alu_op_o !== 4'h0)
            begin n_fail++; $display("FAIL b2b_ctrl: got we%0b imm%0b op %h exp we1 imm1 op 0", ex_if.ex_wr_en_o, ex_if.ex_use_imm_o, ex_if.ex_alu_op_o); end
        tick();
        n_tests++; if (ex_if.ex_valid_o !== 1'b1 || ex_if.ex_imm_o !== 32'd7 || ex_if.ex_rd_o !== 5'd2 || ex_if.ex_pc_o !== 32'h4)
            begin n_fail++; $display("FAIL b2b_second: got v%0b imm %h rd %0d pc %h exp v1 imm 7 rd 2 pc 4", ex_if.ex_valid_o, ex_if.ex_imm_o, ex_if.ex_rd_o, ex_if.ex_pc_o); end
        tick();
        n_tests++; if (ex_if.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %0b exp 0", ex_if.ex_valid_o); end
        idle(4);
    endtask

    task automatic test_raw_hazard();
        offer(32'h80, ADDI_X1_5);
        tick();
        offer(32'h84, ADD_X3);
        tick();
        fetch_valid = 1'b0;
        #1;
        n_tests++; if (dec_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_idex: got %0b exp 1", dec_stall); end
        n_tests++; if (rf_rs1_addr !== 5'd1 || rf_rs2_addr !== 5'd1) begin n_fail++; $display("FAIL raw_rf_addr: got %0d/%0d exp 1/1", rf_rs1_addr, rf_rs2_addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (ex_if.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL raw_bubble%0d: got %0b exp 0", i, ex_if.ex_valid_o); end
            n_tests++; if (dec_stall !== (i < 2)) begin n_fail++; $display("FAIL raw_stall%0d: got %0b exp %0b", i, dec_stall, (i < 2)); end
        end
        tick();
        n_tests++; if (ex_if.ex_valid_o !== 1'b1 || ex_if.ex_rd_o !== 5'd3 || ex_if.ex_pc_o !== 32'h84 || ex_if.ex_use_imm_o !== 1'b0)
            begin n_fail++; $display("FAIL raw_issue: got v%0b rd %0d pc %h ui%0b exp v1 rd 3 pc 84 ui0", ex_if.ex_valid_o, ex_if.ex_rd_o, ex_if.ex_pc_o, ex_if.ex_use_imm_o); end
        n_tests++; if (ex_if.ex_rs1_data_o !== 32'h1000_0001 || ex_if.ex_rs2_data_o !== 32'h1000_0001)
            begin n_fail++; $display("FAIL raw_data: got %h/%h exp 10000001/10000001", ex_if.ex_rs1_data_o, ex_if.ex_rs2_data_o); end
        idle(5);
    endtask

    task automatic test_flush();
        offer(32'h10, ADDI_X1_5);
        tick();
        offer(32'h14, ADDI_X2_7);
        tick();
        offer(32'h18, ADDI_X4_9);
        flush = 1'b1;
        n_tests++; if (ex_if.ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got %0b exp 1", ex_if.ex_valid_o); end
        tick();
        flush = 1'b0;
        fetch_valid = 1'b0;
        #1;
        n_tests++; if (ex_if.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_idex: got %0b exp 0", ex_if.ex_valid_o); end
        n_tests++; if (dec_stall !== 1'b0) begin n_fail++; $display("FAIL flush_ifid: got stall %0b exp 0", dec_stall); end
        tick();
        n_tests++; if (ex_if.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %0b exp 0", ex_if.ex_valid_o); end
        // Flush together with an execute stall
        offer(32'h20, ADDI_X2_7);
        tick();
        fetch_valid = 1'b0;
        tick();
        ex_stall = 1'b1;
        flush = 1'b1;
        tick();
        n_tests++; if (ex_if.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_over_stall: got %0b exp 0", ex_if.ex_valid_o); end
        flush = 1'b0;
        ex_stall = 1'b0;
        idle(4);
    endtask

    task automatic test_ex_stall();
        offer(32'h40, ADDI_X1_5);
        tick();
        offer(32'h44, ADDI_X2_7);
        tick();
        offer(32'h48, ADDI_X4_9);
        ex_stall = 1'b1;
        #1;
        n_tests++; if (dec_stall !== 1'b1) begin n_fail++; $display("FAIL stall_dec0: got %0b exp 1", dec_stall); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (ex_if.ex_valid_o !== 1'b1 || ex_if.ex_rd_o !== 5'd1 || ex_if.ex_pc_o !== 32'h40 || ex_if.ex_imm_o !== 32'd5)
                begin n_fail++; $display("FAIL stall_hold%0d: got v%0b rd %0d pc %h imm %h exp v1 rd 1 pc 40 imm 5", i, ex_if.ex_valid_o, ex_if.ex_rd_o, ex_if.ex_pc_o, ex_if.ex_imm_o); end
            n_tests++; if (dec_stall !== 1'b1) begin n_fail++; $display("FAIL stall_dec%0d: got %0b exp 1", i + 1, dec_stall); end
        end
        ex_stall = 1'b0;
        #1;
        n_tests++; if (dec_stall !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %0b exp 0", dec_stall); end
        tick();
        fetch_valid = 1'b0;
        n_tests++; if (ex_if.ex_valid_o !== 1'b1 || ex_if.ex_rd_o !== 5'd2 || ex_if.ex_pc_o !== 32'h44)
            begin n_fail++; $display("FAIL stall_next: got v%0b rd %0d pc %h exp v1 rd 2 pc 44", ex_if.ex_valid_o, ex_if.ex_rd_o, ex_if.ex_pc_o); end
        tick();
        n_tests++; if (ex_if.ex_valid_o !== 1'b1 || ex_if.ex_rd_o !== 5'd4 || ex_if.ex_pc_o !== 32'h48)
            begin n_fail++; $display("FAIL stall_third: got v%0b rd %0d pc %h exp v1 rd 4 pc 48", ex_if.ex_valid_o, ex_if.ex_rd_o, ex_if.ex_pc_o); end
        tick();
        n_tests++; if (ex_if.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_nodup: got %0b exp 0", ex_if.ex_valid_o); end
        idle(4);
    endtask

    task automatic test_illegal_and_imm();
        ovr_en = 1'b1;
        ovr_exm_we = 1'b1;
        ovr_exm_rd = 5'd0;
        offer(32'hC0, ILLEGAL);
        tick();
        offer(32'hC4, ADDI_X0_1);
        tick();
        offer(32'hC8, SW_X5_M4);
        #1;
        n_tests++; if (ex_if.ex_valid_o !== 1'b1 || ex_if.ex_illegal_o !== 1'b1 || ex_if.ex_wr_en_o !== 1'b0)
            begin n_fail++; $display("FAIL illegal: got v%0b ill%0b we%0b exp v1 ill1 we0", ex_if.ex_valid_o, ex_if.ex_illegal_o, ex_if.ex_wr_en_o); end
        n_tests++; if (ex_if.ex_is_load_o !== 1'b0 || ex_if.ex_is_store_o !== 1'b0 || ex_if.ex_is_branch_o !== 1'b0 || ex_if.ex_is_jal_o !== 1'b0 || ex_if.ex_is_jalr_o !== 1'b0)
            begin n_fail++; $display("FAIL illegal_flags: got ld%0b st%0b br%0b jal%0b jalr%0b exp all 0", ex_if.ex_is_load_o, ex_if.ex_is_store_o, ex_if.ex_is_branch_o, ex_if.ex_is_jal_o, ex_if.ex_is_jalr_o); end
        n_tests++; if (dec_stall !== 1'b0) begin n_fail++; $display("FAIL x0_no_stall: got %0b exp 0", dec_stall); end
        tick();
        offer(32'hCC, SRAI_X6);
        n_tests++; if (ex_if.ex_valid_o !== 1'b1 || ex_if.ex_illegal_o !== 1'b0 || ex_if.ex_wr_en_o !== 1'b0 || ex_if.ex_pc_o !== 32'hC4)
            begin n_fail++; $display("FAIL addi_x0: got v%0b ill%0b we%0b pc %h exp v1 ill0 we0 pc c4", ex_if.ex_valid_o, ex_if.ex_illegal_o, ex_if.ex_wr_en_o, ex_if.ex_pc_o); end
        tick();
        fetch_valid = 1'b0;
        n_tests++; if (ex_if.ex_imm_o !== 32'hFFFF_FFFC || ex_if.ex_is_store_o !== 1'b1 || ex_if.ex_wr_en_o !== 1'b0 || ex_if.ex_funct3_o !== 3'd2)
            begin n_fail++; $display("FAIL sw_decode: got imm %h st%0b we%0b f3 %0d exp fffffffc st1 we0 f3 2", ex_if.ex_imm_o, ex_if.ex_is_store_o, ex_if.ex_wr_en_o, ex_if.ex_funct3_o); end
        n_tests++; if (ex_if.ex_rs1_data_o !== 32'h1000_0002 || ex_if.ex_rs2_data_o !== 32'h1000_0005)
            begin n_fail++; $display("FAIL sw_data: got %h/%h exp 10000002/10000005", ex_if.ex_rs1_data_o, ex_if.ex_rs2_data_o); end
        tick();
        n_tests++; if (ex_if.ex_alu_op_o !== 4'b1101 || ex_if.ex_imm_o !== 32'h0000_0403 || ex_if.ex_rd_o !== 5'd6 || ex_if.ex_wr_en_o !== 1'b1)
            begin n_fail++; $display("FAIL srai_decode: got op %h imm %h rd %0d we%0b exp d 403 6 1", ex_if.ex_alu_op_o, ex_if.ex_imm_o, ex_if.ex_rd_o, ex_if.ex_wr_en_o); end
        ovr_en = 1'b0;
        ovr_exm_we = 1'b0;
        idle(4);
    endtask

    task automatic test_reset_mid();
        offer(32'h100, ADDI_X1_5);
        tick();
        offer(32'h104, ADDI_X2_7);
        tick();
        n_tests++; if (ex_if.ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL mrst_pre: got %0b exp 1", ex_if.ex_valid_o); end
        #1 rst_i = 1'b0;
        #1;
        n_tests++; if (ex_if.ex_valid_o !== 1'b0 || dec_stall !== 1'b0 || ex_if.ex_rd_o !== 5'd0 || ex_if.ex_imm_o !== 32'h0 || ex_if.ex_pc_o !== 32'h0)
            begin n_fail++; $display("FAIL mrst_clear: got v%0b st%0b rd %0d imm %h pc %h exp all 0", ex_if.ex_valid_o, dec_stall, ex_if.ex_rd_o, ex_if.ex_imm_o, ex_if.ex_pc_o); end
        @(negedge clk);
        rst_i = 1'b1;
        tick();
        n_tests++; if (ex_if.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL mrst_edge1: got %0b exp 0", ex_if.ex_valid_o); end
        fetch_valid = 1'b0;
        tick();
        n_tests++; if (ex_if.ex_valid_o !== 1'b1 || ex_if.ex_pc_o !== 32'h104 || ex_if.ex_rd_o !== 5'd2)
            begin n_fail++; $display("FAIL mrst_edge2: got v%0b pc %h rd %0d exp v1 pc 104 rd 2", ex_if.ex_valid_o, ex_if.ex_pc_o, ex_if.ex_rd_o); end
        tick();
        n_tests++; if (ex_if.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL mrst_retained: got %0b exp 0", ex_if.ex_valid_o); end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_raw_hazard();
        test_flush();
        test_ex_stall();
        test_illegal_and_imm();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage, directly downstream of `fetch_stage`. It captures each instruction that fetch hands over into an internal IF/ID register, then decodes it: RV32I base fields, immediates and control flags. It reads the two source registers from the register file and detects RAW hazards against in-flight writers, inserting bubbles when needed. The decoded result is driven to the execute stage through a registered ID/EX interface. Its `dec_stall_o` is computed only from registered state and downstream inputs, so it feeds fetch's `dec_stall_i` without a combinational loop.

## Interface
- `ADDR_WIDTH`, `params_pkg::ADDR_WIDTH`: PC width.
- `DATA_WIDTH`, `params_pkg::DATA_WIDTH`: register and immediate width (32).
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `fetch_valid_i`  in  1  fetch presents an instruction (from fetch `dec_valid_o`).
- `fetch_pc_i`  in  ADDR_WIDTH  PC of the presented instruction.
- `fetch_instr_i`  in  32  instruction word.
- `dec_stall_o`  out  1  IF/ID is occupied and cannot advance; fetch must hold.
- `flush_i`  in  1  taken branch or jump resolved in EX; kill IF/ID and ID/EX.
- `ex_stall_i`  in  1  execute/memory stage cannot accept; hold ID/EX.
- `rf_rs1_addr_o`, `rf_rs2_addr_o`  out  5  register file read addresses (combinational read).
- `rf_rs1_data_i`, `rf_rs2_data_i`  in  DATA_WIDTH  register file read data.
- `exm_wr_en_i`, `exm_rd_i`  in  1/5  writer currently in EX/MEM.
- `wb_wr_en_i`, `wb_rd_i`  in  1/5  writer currently in MEM/WB (register file does not bypass).
- `ex_valid_o`  out  1  ID/EX holds a valid instruction.
- `ex_pc_o`  out  ADDR_WIDTH  instruction PC.
- `ex_rs1_data_o`, `ex_rs2_data_o`, `ex_imm_o`  out  DATA_WIDTH  operands and sign-extended immediate.
- `ex_rd_o`  out  5  destination register.
- `ex_alu_op_o`  out  4  {funct7[5], funct3} for OP; same for OP-IMM with funct3=101, else {0, funct3}; 0000 (ADD) for all other opcodes.
- `ex_funct3_o`  out  3  raw funct3 (branch condition, load/store size).
- `ex_wr_en_o`, `ex_is_load_o`, `ex_is_store_o`, `ex_is_branch_o`, `ex_is_jal_o`, `ex_is_jalr_o`, `ex_is_lui_o`, `ex_is_auipc_o`, `ex_use_imm_o`, `ex_illegal_o`  out  1 each  control flags.

## Operation
- Opcodes decoded:
  - LUI 0110111, AUIPC 0010111: U-type.
  - JAL 1101111: J-type.
  - JALR 1100111: I-type.
  - BRANCH 1100011: B-type.
  - LOAD 0000011: I-type.
  - STORE 0100011: S-type.
  - OP-IMM 0010011: I-type.
  - OP 0110011: R-type.
- Any other opcode sets `ex_illegal_o`=1 and forces `wr_en`, `is_load`, `is_store`, `is_branch`, `is_jal` and `is_jalr` to 0.
- `ex_wr_en_o` = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP with rd≠0. It is 0 whenever rd=0.
- `ex_use_imm_o` = 1 for every opcode except OP and BRANCH.
- Operand use:
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used only by OP, BRANCH and STORE.
  - Register x0 never causes a hazard.
- Hazard: a used rs≠0 matches any of the following:
  - ID/EX (`ex_valid_o` & `ex_wr_en_o` & `ex_rd_o`);
  - (`exm_wr_en_i`, `exm_rd_i`);
  - (`wb_wr_en_i`, `wb_rd_i`).
- There is no forwarding.
- The `rf_*_addr_o` outputs are always driven from IF/ID instr[19:15] and [24:20], even when IF/ID is invalid.
- advance = IF/ID valid & !hazard & !ex_stall_i.
- `dec_stall_o` = IF/ID valid & !advance. It never depends on `fetch_*` inputs.
- ID/EX update, in priority order:
  1. flush: `ex_valid_o`←0.
  2. ex_stall_i: hold all ID/EX fields.
  3. advance: load the decoded fields plus `rf_*_data_i`, and set valid.
  4. Otherwise (hazard or IF/ID empty): bubble, `ex_valid_o`←0, other fields don't-care.
- IF/ID update, in priority order:
  1. flush: valid←0, and any `fetch_valid_i` in the same cycle is discarded.
  2. IF/ID empty or advance: load {`fetch_valid_i`, `fetch_pc_i`, `fetch_instr_i`}.
  3. Otherwise: hold.

## Timing
- Reset (asynchronous assert, synchronous release):
  - IF/ID valid, PC and instr are 0.
  - All ID/EX fields are 0.
  - `ex_valid_o`=0 and `dec_stall_o`=0.
  - Decoding the 0 instruction gives `ex_illegal_o`=0 (gated by valid, so only valid instructions can flag illegal).
- Latency: an instruction accepted at edge N (`fetch_valid_i` & !`dec_stall_o`) has `ex_valid_o`=1 after edge N+1 when there is no hazard. Throughput is 1 per cycle.
- Hazard stalls:
  - Against ID/EX: 3 bubble cycles if the writer advances normally (ID/EX → EX/MEM → MEM/WB → retired).
  - Against EX/MEM: 2 bubble cycles.
  - Against MEM/WB: 1 bubble cycle.
- Reset in mid-stall or mid-flush clears everything immediately. No instruction is retained.
- Flush while `ex_stall_i`=1: flush wins and `ex_valid_o` drops on the next edge.

## Test plan
- Reset: hold `rst_i`=0 mid-stream, then release → all outputs 0 immediately. The first accepted instruction appears 2 edges later.
- Back-to-back `addi x1,x0,5` @PC 0 then `addi x2,x0,7` @PC 4 (no hazard) → `ex_valid_o`=1 on consecutive cycles, `ex_imm_o`=5 then 7, `ex_rd_o`=1 then 2, `dec_stall_o` never asserted.
- `addi x1,x0,5` followed by `add x3,x1,x1` → `dec_stall_o`=1 for 3 cycles, 3 bubbles (`ex_valid_o`=0), then `add` issues with `rf_rs1_addr_o`=1.
- `flush_i` pulsed while IF/ID and ID/EX are both valid and `fetch_valid_i`=1 → next cycle `ex_valid_o`=0, IF/ID empty, and the offered instruction is dropped.
- `ex_stall_i`=1 for 4 cycles with a valid ID/EX → `ex_*` outputs are stable, `dec_stall_o`=1 while IF/ID is valid, and there is no loss or duplication after release.
- Instruction 0xFFFFFFFF (illegal), then `addi x0,x0,1` with `exm_rd_i`=0 and `exm_wr_en_i`=1 → first gives `ex_illegal_o`=1 and `ex_wr_en_o`=0. Second gives no stall and `ex_wr_en_o`=0. `sw x5,-4(x2)` → `ex_imm_o`=0xFFFFFFFC, `ex_is_store_o`=1.
